if_id_queue: RTL

Fetch-to-decode buffer for the instruction datapath. Captures each {PC, instruction} pair produced by the fetch stage into a small circular queue and presents the oldest entry to decode through a valid/ready handshake. Decouples decode stalls from fetch and discards wrong-path instructions on a taken jump or branch.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/queue_ram.sv | 32 +++
 rtl/if_id_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pkg
// Brief    : Constants shared by the fetch, fetch-to-decode queue and decode
//            stages of the instruction datapath.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;

  // Instruction presented to decode when there is nothing to issue (bubble)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // PC presented alongside a bubble and after reset
  localparam logic [5:0]  PC_RESET  = 6'h00;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/queue_ram.sv
`default_nettype none
// ============================================================================
// Module   : queue_ram
// Brief    : DEPTH-entry register array, synchronous write, asynchronous read.
//            Contents are never reset; validity is tracked by the owner.
// Revision : 1.0 - initial release
// ============================================================================
module queue_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Capture the write data into the addressed entry
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : queue_ram
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Brief    : Fetch-to-decode circular queue of {PC, instruction} pairs with
//            valid/ready handshakes on both sides and a redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = datapath_pkg::PC_W,
  parameter int INSTR_W = datapath_pkg::INSTR_W
) (
  input  logic                     reloj,
  input  logic                     reset,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [PC_W-1:0]          pc_out,
  output logic [PC_W-1:0]          pc_plus1_out,
  output logic [INSTR_W-1:0]       instr_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  import datapath_pkg::*;

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_EW = PC_W + INSTR_W;

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic            w_push;
  logic            w_pop;
  logic [c_EW-1:0] w_rd_entry;

  // Readiness depends on occupancy only, so a full queue never accepts a
  // push even if decode pops in the same cycle.
  assign in_ready  = (r_count < c_CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  // Storage write is suppressed during flush so the dropped pair never lands
  queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (c_EW)
  ) u_ram (
    .i_clk   (reloj),
    .i_we    (w_push & ~flush),
    .i_waddr (r_wr_ptr),
    .i_wdata ({pc_in, instr_in}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  // Pointer and occupancy update; flush overrides any handshake this cycle
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  // Empty queue shows decode a bubble rather than stale storage
  always_comb begin
    pc_out    = PC_W'(PC_RESET);
    instr_out = INSTR_W'(NOP_INSTR);
    if (out_valid) begin
      pc_out    = w_rd_entry[c_EW-1:INSTR_W];
      instr_out = w_rd_entry[INSTR_W-1:0];
    end
  end

  assign pc_plus1_out = pc_out + PC_W'(1);

endmodule : if_id_queue
`default_nettype wire
